mapper_001: RTL and testbench
=============================

MAPPER_001 -- requirements
Module: mapper_001

Interface
REQ-001 SHALL have parameter PRG_ROM_DEPTH, default 18, PRG ROM byte-address width (256 KiB).
REQ-002 SHALL have parameter CHR_ROM_DEPTH, default 17, CHR byte-address width (128 KiB).
REQ-003 SHALL have parameter PRG_RAM_DEPTH, default 13, PRG RAM byte-address width (8 KiB).
REQ-004 Ports (name direction width meaning):
- clk_cpu in 1: sole clock, one edge per CPU bus cycle.
- rst in 1: reset, asynchronous, active-high.
- cpu_addr in 15: CPU address bits 14:0.
- cpu_data_i in 8: CPU write data.
- ppu_addr in 14: PPU address.
- cpu_rw in 1: 1 = read, 0 = write.
- romsel in 1: 1 = access to $8000-$FFFF.
- mirrorv in 1: header mirroring; port compatibility only, unused.
- chr_ram in 1: CHR is RAM; addressing unchanged.
- prg_ram in 1: cartridge has PRG RAM.
- prg_mask in PRG_ROM_DEPTH: PRG size mask.
- chr_mask in CHR_ROM_DEPTH: CHR size mask.
- prgram_mask in PRG_RAM_DEPTH: PRG RAM size mask.
- prg_addr, chr_addr, prgram_addr out (matching widths): memory addresses.
- prg_cs, chr_cs, prgram_cs out 1: chip selects.
- mapper_reg_o out 8: debug register view.
- ciram_ce, ciram_a10, irq out 1: nametable enable, nametable A10, interrupt.

Function
REQ-005 A qualifying write SHALL be romsel=1 and cpu_rw=0 at a clk_cpu rising edge, with no qualifying write on the previous edge; back-to-back writes after the first SHALL be ignored.
REQ-006 On a qualifying write with cpu_data_i[7]=1: shift register and count SHALL clear, and control[3:2] SHALL be set to 2'b11, other control bits kept.
REQ-007 On a qualifying write with cpu_data_i[7]=0 and count<4: shift <= {cpu_data_i[0], shift[4:1]}, count <= count+1.
REQ-008 On the qualifying write with count=4 and cpu_data_i[7]=0: value {cpu_data_i[0], shift[4:1]} SHALL load the register chosen by cpu_addr[14:13] (0 control, 1 chr0, 2 chr1, 3 prg). Shift and count SHALL clear on the same edge.
REQ-009 A loaded register SHALL affect outputs from the cycle after the load edge; address outputs are combinational from registers and current bus.
REQ-010 Mirroring control[1:0]: 0 ciram_a10=0; 1 ciram_a10=1; 2 ciram_a10=ppu_addr[10]; 3 ciram_a10=ppu_addr[11]. ciram_ce=ppu_addr[13]; chr_cs=~ciram_ce.
REQ-011 PRG mode control[3:2], 16 KiB bank B:
- 0/1: B={prg[3:1],cpu_addr[14]}.
- 2: B=0 when cpu_addr[14]=0, else prg[3:0].
- 3: B=prg[3:0] when cpu_addr[14]=0, else 4'hF.
- prg_addr = prg_mask & {B, cpu_addr[13:0]}, zero-extended/truncated to PRG_ROM_DEPTH; prg_cs=romsel.
REQ-012 CHR mode control[4], 4 KiB bank C:
- 0: C={chr0[4:1],ppu_addr[12]}.
- 1: C = ppu_addr[12] ? chr1 : chr0.
- chr_addr = chr_mask & {C, ppu_addr[11:0]}, fitted to CHR_ROM_DEPTH.
REQ-013 prgram_cs SHALL be prg_ram & ~prg[4] & ~romsel & (cpu_addr[14:13]==2'b11); prgram_addr = prgram_mask & cpu_addr[12:0].
REQ-014 Writes to $6000-$7FFF and all reads SHALL NOT change mapper state.
REQ-015 irq SHALL be constant 0; mapper_reg_o = {count[2:0], control[4:0]}.

Reset
REQ-016 While rst=1: shift=0, count=0, control=5'b01100, chr0=0, chr1=0, prg=0, previous-write flag=0; a partial 5-write sequence SHALL be discarded.
REQ-017 The first qualifying write after rst deasserts SHALL be accepted; the consecutive-write filter is clear.

Structure
REQ-018 A shared package SHALL hold mirroring and PRG-mode enums, register-select encoding and the control reset constant 5'b01100.
REQ-019 Sub-module mmc1_serial_loader SHALL implement the write filter, shift, count and register-select strobe; mapper_001 holds the bank registers and address muxes.

Verification
REQ-020 Five writes to $E000 with data bits 0,1,0,0,0, one idle cycle apart -> prg=5'b00010; $8000 -> prg_addr=0x08000; $C000 -> 0x3C000.
REQ-021 Write 0x80, then five writes with bits 1,1,0,0,0 to $8000 -> mirroring=3 (horizontal); PRG mode 0; cpu_addr $C123 -> prg_addr=0x04123 with prg=0.
REQ-022 Two writes 0x01 on consecutive edges -> count=1, not 2.
REQ-023 Three shift writes, then 0x80 -> count=0, control[3:2]=3, bank registers unchanged.
REQ-024 CHR mode 1, chr0=3, chr1=7: ppu_addr 0x0040 -> chr_addr=0x03040; 0x1040 -> 0x07040.
REQ-025 Assert rst after two shift writes -> mapper_reg_o=0x0C, then a full sequence loads correctly.

Source files
------------

// File: rtl/mapper_001_pkg.sv
// Shared types and constants for the MMC1-style mapper (mapper_001).
package mapper_001_pkg;

    typedef enum logic [1:0] {
        MIR_ONE_LO = 2'd0,
        MIR_ONE_HI = 2'd1,
        MIR_VERT   = 2'd2,
        MIR_HORIZ  = 2'd3
    } mirror_e;

    typedef enum logic [1:0] {
        PRG_32K_A     = 2'd0,
        PRG_32K_B     = 2'd1,
        PRG_FIX_FIRST = 2'd2,
        PRG_FIX_LAST  = 2'd3
    } prg_mode_e;

    typedef enum logic [1:0] {
        SEL_CONTROL = 2'd0,
        SEL_CHR0    = 2'd1,
        SEL_CHR1    = 2'd2,
        SEL_PRG     = 2'd3
    } reg_sel_e;

    localparam logic [4:0] CONTROL_RESET = 5'b01100;
    localparam logic [2:0] LAST_COUNT    = 3'd4;

endpackage

// File: rtl/mapper_001_serial_loader.sv
// MMC1 serial port: consecutive-write filter, 5-bit shift register and load strobe.
module mmc1_serial_loader
    import mapper_001_pkg::*;
(
    input  logic       clk_cpu,
    input  logic       rst,
    input  logic       i_romsel,
    input  logic       i_cpu_rw,
    input  logic       i_data_msb,
    input  logic       i_data_lsb,
    input  logic [1:0] i_reg_sel,
    output logic       o_load,
    output logic       o_clear,
    output logic [1:0] o_sel,
    output logic [4:0] o_value,
    output logic [2:0] o_count
);

    logic       r_prev_write;
    logic [4:0] r_shift;
    logic [2:0] r_count;
    logic       w_write;
    logic       w_accept;

    // A write on the edge right after another write is a CPU RMW artefact and is dropped.
    assign w_write  = i_romsel & ~i_cpu_rw;
    assign w_accept = w_write & ~r_prev_write;

    assign o_clear = w_accept & i_data_msb;
    assign o_load  = w_accept & ~i_data_msb & (r_count == LAST_COUNT);
    assign o_value = {i_data_lsb, r_shift[4:1]};
    assign o_sel   = i_reg_sel;
    assign o_count = r_count;

    always_ff @(posedge clk_cpu or posedge rst) begin
        if (rst) begin
            r_prev_write <= 1'b0;
            r_shift      <= 5'd0;
            r_count      <= 3'd0;
        end else begin
            // NOTE: non-blocking so every register here samples the pre-edge values.
            r_prev_write <= w_write;
            if (w_accept) begin
                if (i_data_msb || r_count == LAST_COUNT) begin
                    r_shift <= 5'd0;
                    r_count <= 3'd0;
                end else begin
                    r_shift <= {i_data_lsb, r_shift[4:1]};
                    r_count <= r_count + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/mapper_001.sv
// MMC1-style mapper: bank registers loaded from the serial port, PRG/CHR/CIRAM address muxes.
module mapper_001
    import mapper_001_pkg::*;
#(
    parameter int PRG_ROM_DEPTH = 18,
    parameter int CHR_ROM_DEPTH = 17,
    parameter int PRG_RAM_DEPTH = 13
) (
    input  logic                     clk_cpu,
    input  logic                     rst,
    input  logic [14:0]              cpu_addr,
    input  logic [7:0]               cpu_data_i,
    input  logic [13:0]              ppu_addr,
    input  logic                     cpu_rw,
    input  logic                     romsel,
    input  logic                     mirrorv,
    input  logic                     chr_ram,
    input  logic                     prg_ram,
    input  logic [PRG_ROM_DEPTH-1:0] prg_mask,
    input  logic [CHR_ROM_DEPTH-1:0] chr_mask,
    input  logic [PRG_RAM_DEPTH-1:0] prgram_mask,
    output logic [PRG_ROM_DEPTH-1:0] prg_addr,
    output logic [CHR_ROM_DEPTH-1:0] chr_addr,
    output logic [PRG_RAM_DEPTH-1:0] prgram_addr,
    output logic                     prg_cs,
    output logic                     chr_cs,
    output logic                     prgram_cs,
    output logic [7:0]               mapper_reg_o,
    output logic                     ciram_ce,
    output logic                     ciram_a10,
    output logic                     irq
);

    logic [4:0] r_control;
    logic [4:0] r_chr0;
    logic [4:0] r_chr1;
    logic [4:0] r_prg;

    logic       w_load;
    logic       w_clear;
    logic [1:0] w_sel;
    logic [4:0] w_value;
    logic [2:0] w_count;
    logic [3:0] w_prg_bank;
    logic [4:0] w_chr_bank;
    logic       w_unused_pins;

    // Header mirroring is superseded by the control register; CHR RAM uses the same addressing.
    assign w_unused_pins = ^{mirrorv, chr_ram, cpu_data_i[6:1]};

    mmc1_serial_loader u_loader (
        .clk_cpu    (clk_cpu),
        .rst        (rst),
        .i_romsel   (romsel),
        .i_cpu_rw   (cpu_rw),
        .i_data_msb (cpu_data_i[7]),
        .i_data_lsb (cpu_data_i[0]),
        .i_reg_sel  (cpu_addr[14:13]),
        .o_load     (w_load),
        .o_clear    (w_clear),
        .o_sel      (w_sel),
        .o_value    (w_value),
        .o_count    (w_count)
    );

    always_ff @(posedge clk_cpu or posedge rst) begin
        if (rst) begin
            r_control <= CONTROL_RESET;
            r_chr0    <= 5'd0;
            r_chr1    <= 5'd0;
            r_prg     <= 5'd0;
        end else if (w_clear) begin
            r_control <= r_control | CONTROL_RESET;
        end else if (w_load) begin
            case (reg_sel_e'(w_sel))
                SEL_CONTROL: r_control <= w_value;
                SEL_CHR0:    r_chr0    <= w_value;
                SEL_CHR1:    r_chr1    <= w_value;
                SEL_PRG:     r_prg     <= w_value;
                default:     r_prg     <= r_prg;
            endcase
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned and infers a latch.
        w_prg_bank = 4'h0;
        case (prg_mode_e'(r_control[3:2]))
            PRG_32K_A, PRG_32K_B: w_prg_bank = {r_prg[3:1], cpu_addr[14]};
            PRG_FIX_FIRST:        w_prg_bank = cpu_addr[14] ? r_prg[3:0] : 4'h0;
            PRG_FIX_LAST:         w_prg_bank = cpu_addr[14] ? 4'hF : r_prg[3:0];
            default:              w_prg_bank = 4'h0;
        endcase

        w_chr_bank = r_chr0;
        if (r_control[4]) w_chr_bank = ppu_addr[12] ? r_chr1 : r_chr0;
        else              w_chr_bank = {r_chr0[4:1], ppu_addr[12]};

        ciram_a10 = 1'b0;
        case (mirror_e'(r_control[1:0]))
            MIR_ONE_LO: ciram_a10 = 1'b0;
            MIR_ONE_HI: ciram_a10 = 1'b1;
            MIR_VERT:   ciram_a10 = ppu_addr[10];
            MIR_HORIZ:  ciram_a10 = ppu_addr[11];
            default:    ciram_a10 = 1'b0;
        endcase
    end

    assign prg_addr    = prg_mask & PRG_ROM_DEPTH'({w_prg_bank, cpu_addr[13:0]});
    assign chr_addr    = chr_mask & CHR_ROM_DEPTH'({w_chr_bank, ppu_addr[11:0]});
    assign prgram_addr = prgram_mask & PRG_RAM_DEPTH'(cpu_addr[12:0]);
    assign prg_cs      = romsel;
    assign ciram_ce    = ppu_addr[13];
    assign chr_cs      = ~ppu_addr[13];
    assign prgram_cs   = prg_ram & ~r_prg[4] & ~romsel & (cpu_addr[14:13] == 2'b11);
    assign mapper_reg_o = {w_count, r_control};
    assign irq         = 1'b0;

endmodule

// File: tb/tb_mapper_001.sv
// Self-checking bench for mapper_001: directed scenarios plus random bus traffic vs. a register-level model.
module tb_mapper_001;

    logic        clk_cpu = 1'b0;
    logic        rst;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_data_i;
    logic [13:0] ppu_addr;
    logic        cpu_rw, romsel, mirrorv, chr_ram, prg_ram;
    logic [17:0] prg_mask;
    logic [16:0] chr_mask;
    logic [12:0] prgram_mask;
    logic [17:0] prg_addr;
    logic [16:0] chr_addr;
    logic [12:0] prgram_addr;
    logic        prg_cs, chr_cs, prgram_cs, ciram_ce, ciram_a10, irq;
    logic [7:0]  mapper_reg_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model: m_reg[0]=control, [1]=chr0, [2]=chr1, [3]=prg; q_bits holds the serial bits so far.
    int unsigned m_reg [4];
    bit          q_bits[$];
    bit          m_prev;

    mapper_001 dut (
        .clk_cpu(clk_cpu), .rst(rst), .cpu_addr(cpu_addr), .cpu_data_i(cpu_data_i),
        .ppu_addr(ppu_addr), .cpu_rw(cpu_rw), .romsel(romsel), .mirrorv(mirrorv),
        .chr_ram(chr_ram), .prg_ram(prg_ram), .prg_mask(prg_mask), .chr_mask(chr_mask),
        .prgram_mask(prgram_mask), .prg_addr(prg_addr), .chr_addr(chr_addr),
        .prgram_addr(prgram_addr), .prg_cs(prg_cs), .chr_cs(chr_cs), .prgram_cs(prgram_cs),
        .mapper_reg_o(mapper_reg_o), .ciram_ce(ciram_ce), .ciram_a10(ciram_a10), .irq(irq)
    );

    always #5 clk_cpu = ~clk_cpu;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_reg[0] = 32'h0C;
        m_reg[1] = 0;
        m_reg[2] = 0;
        m_reg[3] = 0;
        q_bits.delete();
        m_prev = 1'b0;
    endtask

    task automatic model_edge();
        bit w;
        int unsigned val;
        w = romsel && !cpu_rw;
        if (w && !m_prev) begin
            if (cpu_data_i[7]) begin
                q_bits.delete();
                m_reg[0] = m_reg[0] | 32'h0C;
            end else begin
                q_bits.push_back(cpu_data_i[0]);
                if (q_bits.size() == 5) begin
                    val = 0;
                    for (int i = 0; i < 5; i++) val += int'(q_bits[i]) << i;
                    m_reg[cpu_addr / 8192] = val;
                    q_bits.delete();
                end
            end
        end
        m_prev = w;
    endtask

    function automatic int unsigned exp_reg();
        return (q_bits.size() << 5) | m_reg[0];
    endfunction

    function automatic int unsigned exp_prg(input int unsigned a);
        int unsigned mode, prg, hi, bank;
        mode = (m_reg[0] >> 2) & 3;
        prg  = m_reg[3];
        hi   = (a >> 14) & 1;
        if (mode < 2)       bank = (prg & 14) + hi;
        else if (mode == 2) bank = hi ? (prg & 15) : 0;
        else                bank = hi ? 15 : (prg & 15);
        return (bank * 16384 + (a % 16384)) & prg_mask;
    endfunction

    function automatic int unsigned exp_chr(input int unsigned p);
        int unsigned hi, bank;
        hi = (p >> 12) & 1;
        if ((m_reg[0] & 16) != 0) bank = hi ? m_reg[2] : m_reg[1];
        else                      bank = (m_reg[1] & 30) + hi;
        return (bank * 4096 + (p % 4096)) & chr_mask;
    endfunction

    function automatic int unsigned exp_a10(input int unsigned p);
        case (m_reg[0] & 3)
            0:       return 0;
            1:       return 1;
            2:       return (p >> 10) & 1;
            default: return (p >> 11) & 1;
        endcase
    endfunction

    // One bus cycle: drive, let the DUT and model see the edge, settle just after it.
    task automatic bus(input logic rs, input logic rw, input logic [14:0] a, input logic [7:0] d);
        romsel = rs; cpu_rw = rw; cpu_addr = a; cpu_data_i = d;
        @(posedge clk_cpu);
        model_edge();
        #1;
    endtask

    task automatic idle();
        bus(1'b0, 1'b1, 15'h0000, 8'h00);
    endtask

    task automatic write5(input logic [14:0] a, input logic [4:0] v);
        for (int i = 0; i < 5; i++) begin
            bus(1'b1, 1'b0, a, {7'd0, v[i]});
            idle();
        end
    endtask

    task automatic probe(input string tag, input logic rs, input logic [14:0] a, input logic [13:0] p);
        int unsigned pcs;
        romsel = rs; cpu_rw = 1'b1; cpu_addr = a; ppu_addr = p;
        #1;
        pcs = (prg_ram && ((m_reg[3] >> 4) & 1) == 0 && !rs && (a / 8192) == 3) ? 1 : 0;
        check({tag, ".reg"},       mapper_reg_o, exp_reg());
        check({tag, ".prg_addr"},  prg_addr,     exp_prg(a));
        check({tag, ".chr_addr"},  chr_addr,     exp_chr(p));
        check({tag, ".a10"},       ciram_a10,    exp_a10(p));
        check({tag, ".ce"},        ciram_ce,     (p >> 13) & 1);
        check({tag, ".chr_cs"},    chr_cs,       ((p >> 13) & 1) ^ 1);
        check({tag, ".prg_cs"},    prg_cs,       rs);
        check({tag, ".prgram_cs"}, prgram_cs,    pcs);
        check({tag, ".prgram_a"},  prgram_addr,  (a % 8192) & prgram_mask);
        check({tag, ".irq"},       irq,          0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check("reset.reg", mapper_reg_o, 32'h0C);
        @(posedge clk_cpu); #1;
        @(posedge clk_cpu); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cpu_addr = 0; cpu_data_i = 0; ppu_addr = 0; cpu_rw = 1'b1; romsel = 1'b0;
        mirrorv = 1'b0; chr_ram = 1'b0; prg_ram = 1'b1;
        prg_mask = '1; chr_mask = '1; prgram_mask = '1;
        model_reset();
        do_reset();
        probe("reset", 1'b1, 15'h4000, 14'h0800);

        // PRG=2 in fix-last mode
        write5(15'h6000, 5'b00010);
        probe("req020", 1'b1, 15'h0000, 14'h0000);
        romsel = 1'b1; cpu_addr = 15'h0000; #1;
        check("req020.lo", prg_addr, 32'h08000);
        cpu_addr = 15'h4000; #1;
        check("req020.hi", prg_addr, 32'h3C000);

        // Control = 00011 after a reset write: horizontal mirroring, 32K PRG
        do_reset();
        bus(1'b1, 1'b0, 15'h0000, 8'h80);
        idle();
        write5(15'h0000, 5'b00011);
        romsel = 1'b1; cpu_addr = 15'h4123; ppu_addr = 14'h0800; #1;
        check("req021.prg", prg_addr, 32'h04123);
        check("req021.a10_hi", ciram_a10, 1);
        ppu_addr = 14'h0400; #1;
        check("req021.a10_lo", ciram_a10, 0);
        check("req021.reg", mapper_reg_o, 32'h03);
        probe("req021", 1'b1, 15'h4123, 14'h2C00);

        // Back-to-back writes: only the first counts
        bus(1'b1, 1'b0, 15'h2000, 8'h01);
        bus(1'b1, 1'b0, 15'h2000, 8'h01);
        idle();
        check("req022.count", mapper_reg_o[7:5], 1);
        probe("req022", 1'b1, 15'h0000, 14'h1000);

        // Partial sequence aborted by bit 7
        bus(1'b1, 1'b0, 15'h2000, 8'h01); idle();
        bus(1'b1, 1'b0, 15'h2000, 8'h00); idle();
        bus(1'b1, 1'b0, 15'h2000, 8'hFE); idle();
        check("req023.reg", mapper_reg_o, 32'h0F);
        probe("req023", 1'b1, 15'h4123, 14'h1234);

        // RAM-window writes and reads leave the mapper alone
        bus(1'b0, 1'b0, 15'h6000, 8'h01); idle();
        bus(1'b1, 1'b1, 15'h6000, 8'h01); idle();
        check("req014.reg", mapper_reg_o, 32'h0F);
        probe("req013", 1'b0, 15'h7ABC, 14'h0000);

        // CHR 4K mode: chr0=3, chr1=7
        write5(15'h0000, 5'b11100);
        write5(15'h2000, 5'b00011);
        write5(15'h4000, 5'b00111);
        ppu_addr = 14'h0040; #1;
        check("req024.lo", chr_addr, 32'h03040);
        ppu_addr = 14'h1040; #1;
        check("req024.hi", chr_addr, 32'h07040);
        probe("req024", 1'b1, 15'h0000, 14'h1FFF);

        // Reset mid-sequence, then the first write afterwards is accepted
        bus(1'b1, 1'b0, 15'h6000, 8'h01); idle();
        bus(1'b1, 1'b0, 15'h6000, 8'h01);
        do_reset();
        check("req025.reg", mapper_reg_o, 32'h0C);
        write5(15'h6000, 5'b00101);
        romsel = 1'b1; cpu_addr = 15'h0000; #1;
        check("req025.prg", prg_addr, 32'h14000);
        probe("req025", 1'b1, 15'h4000, 14'h0000);

        // Random traffic with random size masks
        for (int n = 0; n < 600; n++) begin
            int unsigned op;
            logic [7:0] d;
            if (n % 100 == 0) begin
                prg_mask    = 18'((1 << $urandom_range(15, 18)) - 1);
                chr_mask    = 17'((1 << $urandom_range(13, 17)) - 1);
                prgram_mask = 13'((1 << $urandom_range(11, 13)) - 1);
                prg_ram     = 1'($urandom_range(0, 1));
            end
            op = $urandom_range(0, 9);
            d  = 8'($urandom);
            if ($urandom_range(0, 7) != 0) d[7] = 1'b0;
            if (op < 5)      bus(1'b1, 1'b0, 15'($urandom), d);
            else if (op == 5) bus(1'b0, 1'b0, {2'b11, 13'($urandom)}, d);
            else if (op < 8) bus(1'($urandom_range(0, 1)), 1'b1, 15'($urandom), d);
            else             idle();
            probe("rand", 1'($urandom_range(0, 1)), 15'($urandom), 14'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
